commit_trace_unit: RTL and testbench

- Synthesizable commit monitor on the CPU's X/M-stage commit signals.
- Counts cycles and retired instructions, detects halt, and enforces a cycle-limit watchdog.
- Captures one trace record per committing cycle into a parametrised FIFO, read out through a valid/ready port.
- Lets on-chip or debug logic see the REG/LOAD/STORE trace without simulation-only file I/O.

---
 rtl/commit_trace_unit_if.sv | 37 +++
 rtl/commit_trace_unit.sv | 195 +++++++++++++++++++
 tb/tb_commit_trace_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_unit_if.sv
// Commit-side and trace-side signals of the commit trace unit.
// The master drives the commit stream and the trace_ready back-pressure.
// The slave (the trace unit) returns the head trace record.
interface commit_trace_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
) ();

  localparam int REC_W = 4 + 3 * DATA_W + REG_W + ADDR_W;

  logic [DATA_W-1:0] pc;
  logic              reg_write;
  logic [REG_W-1:0]  reg_dest;
  logic [DATA_W-1:0] wb_data;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              hlt;
  logic              trace_ready;
  logic              trace_valid;
  logic [REC_W-1:0]  trace_data;

  modport master (
    output pc, reg_write, reg_dest, wb_data, mem_read, mem_write,
           mem_addr, mem_data, hlt, trace_ready,
    input  trace_valid, trace_data
  );

  modport slave (
    input  pc, reg_write, reg_dest, wb_data, mem_read, mem_write,
           mem_addr, mem_data, hlt, trace_ready,
    output trace_valid, trace_data
  );

endinterface

// File: rtl/commit_trace_unit.sv
// Commit trace unit: counts RUN cycles and retired instructions, stops on
// halt or on the cycle-limit watchdog, and buffers one trace record per
// committing cycle in a FIFO that is drained through a valid/ready port.
module commit_trace_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  commit_trace_unit_if.slave   bus,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     inst_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 halted,
  output logic                 timeout,
  output logic                 done
);

  localparam int REC_W = 4 + 3 * DATA_W + REG_W + ADDR_W;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYCLE_LIMIT);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic             WD_EN    = (CYCLE_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_STOP = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e            state_q;
  logic              halted_q;
  logic              timeout_q;
  logic              done_q;

  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  inst_cnt_q,  inst_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [REC_W-1:0]  mem_d [DEPTH];

  logic              run_s;
  logic              empty_s;
  logic              full_s;
  logic [3:0]        kind_s;
  logic              capture_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              retire_s;
  logic              stop_hlt_s;
  logic              stop_wd_s;
  logic [REC_W-1:0]  rec_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s   = (wptr_q == rptr_q);
  assign full_s    = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                     (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);

  assign run_s     = (state_q == ST_RUN);
  assign kind_s    = {bus.hlt, bus.mem_write, bus.mem_read, bus.reg_write};
  assign capture_s = run_s && (kind_s != 4'b0000);
  assign pop_s     = !empty_s && bus.trace_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push_s    = capture_s && (!full_s || pop_s);
  assign drop_s    = capture_s && full_s && !pop_s;
  assign retire_s  = bus.hlt | bus.reg_write | bus.mem_write;
  assign rec_s     = {kind_s, bus.pc, bus.reg_dest, bus.wb_data,
                      bus.mem_addr, bus.mem_data};

  // Halt wins over the watchdog when both hit on the same cycle.
  assign stop_hlt_s = run_s && bus.hlt;
  assign stop_wd_s  = run_s && !bus.hlt && WD_EN &&
                      ((cycle_cnt_q + CNT_ONE) == LIMIT);

  assign bus.trace_valid = !empty_s;
  assign bus.trace_data  = empty_s ? {REC_W{1'b0}} : mem_q[rptr_q[IDX_W-1:0]];

  assign cycle_count = cycle_cnt_q;
  assign inst_count  = inst_cnt_q;
  assign drop_count  = drop_cnt_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign done        = done_q;

  // Next-state of counters, FIFO pointers and FIFO storage.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mem_d       = mem_q;

    if (run_s) begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      if (retire_s) begin
        inst_cnt_d = inst_cnt_q + CNT_ONE;
      end else begin
        inst_cnt_d = inst_cnt_q;
      end
    end else begin
      cycle_cnt_d = cycle_cnt_q;
      inst_cnt_d  = inst_cnt_q;
    end

    if (drop_s && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (push_s) begin
      mem_d[wptr_q[IDX_W-1:0]] = rec_s;
      wptr_d                   = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Counter, pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= {CNT_W{1'b0}};
      inst_cnt_q  <= {CNT_W{1'b0}};
      drop_cnt_q  <= {CNT_W{1'b0}};
      wptr_q      <= {PTR_W{1'b0}};
      rptr_q      <= {PTR_W{1'b0}};
      mem_q       <= '{default: {REC_W{1'b0}}};
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
    end
  end

  // Run/stop/done sequencer with registered halted, timeout and done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop_hlt_s) begin
            state_q  <= ST_STOP;
            halted_q <= 1'b1;
          end else if (stop_wd_s) begin
            state_q   <= ST_STOP;
            timeout_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_STOP: begin
          if (empty_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_STOP;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Randomised scoreboard bench for commit_trace_unit with a small
// behavioural model (record queue plus occupancy count).
module tb_commit_trace_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;
  localparam int LIMIT  = 20;
  localparam int REC_W  = 4 + 3 * DATA_W + REG_W + ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CNT_W-1:0]  cycle_count, inst_count, drop_count;
  logic              halted, timeout, done;

  commit_trace_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  commit_trace_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W), .CYCLE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .halted(halted), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [REC_W-1:0] exp_q[$];
  int               m_occ;
  logic [CNT_W-1:0] m_cycles, m_inst, m_drop;
  bit               m_stop, m_done, m_halted, m_timeout;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_occ = 0; m_cycles = '0; m_inst = '0; m_drop = '0;
    m_stop = 0; m_done = 0; m_halted = 0; m_timeout = 0;
  endtask

  task automatic clear_in();
    bus.pc = '0; bus.reg_write = 1'b0; bus.reg_dest = '0; bus.wb_data = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0;
    bus.mem_data = '0; bus.hlt = 1'b0; bus.trace_ready = 1'b0;
  endtask

  task automatic rand_payload();
    bus.pc = 16'($urandom); bus.reg_dest = 4'($urandom);
    bus.wb_data = 16'($urandom); bus.mem_addr = 16'($urandom);
    bus.mem_data = 16'($urandom);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_valid", bus.trace_valid, 0);
    check("rst_data", bus.trace_data, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_inst", inst_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout, 0);
    check("rst_done", done, 0);
    model_reset();
    clear_in();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Apply the current inputs for one clock edge, advancing the model first.
  task automatic tick();
    logic [REC_W-1:0] rec;
    bit pop, cap, empty_before;
    pop = (m_occ > 0) && bus.trace_ready;
    empty_before = (m_occ == 0);
    cap = !m_stop && (bus.hlt || bus.mem_write || bus.mem_read || bus.reg_write);
    if (cap) begin
      rec = {bus.hlt, bus.mem_write, bus.mem_read, bus.reg_write, bus.pc,
             bus.reg_dest, bus.wb_data, bus.mem_addr, bus.mem_data};
      if (m_occ == DEPTH && !pop) begin
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end else begin
        exp_q.push_back(rec);
        m_occ++;
      end
    end
    if (pop) m_occ--;
    if (!m_stop) begin
      m_cycles++;
      if (bus.hlt || bus.reg_write || bus.mem_write) m_inst++;
      if (bus.hlt) begin m_halted = 1; m_stop = 1; end
      else if (m_cycles == LIMIT) begin m_timeout = 1; m_stop = 1; end
    end else if (!m_done && empty_before) begin
      m_done = 1;
    end
    @(posedge clk); #1;
    check("cycle_count", cycle_count, m_cycles);
    check("inst_count", inst_count, m_inst);
    check("drop_count", drop_count, m_drop);
    check("halted", halted, m_halted);
    check("timeout", timeout, m_timeout);
    check("done", done, m_done);
    check("trace_valid", bus.trace_valid, m_occ > 0);
  endtask

  task automatic drain(int budget);
    clear_in();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < budget && !m_done; i++) tick();
    check("drain_done", done, 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare the head record whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.trace_valid) begin
        if (bus.trace_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_record: got %0h required none", bus.trace_data);
          end else begin
            check("trace_data", bus.trace_data, exp_q.pop_front());
          end
        end
      end else begin
        check("trace_data_empty", bus.trace_data, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    model_reset();
    #1;
    do_reset();

    // idle, single register write, then a load
    repeat (5) tick();
    check("idle_cycles", cycle_count, 5);
    check("idle_inst", inst_count, 0);
    bus.reg_write = 1'b1; bus.reg_dest = 4'd3; bus.wb_data = 16'h1234;
    bus.pc = 16'h0002; bus.trace_ready = 1'b1;
    tick();
    check("rw_inst", inst_count, 1);
    check("rw_kind", bus.trace_data[REC_W-1 -: 4], 4'b0001);
    clear_in(); bus.trace_ready = 1'b1;
    tick();
    bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.mem_addr = 16'h0040;
    bus.mem_data = 16'hBEEF; bus.pc = 16'h0004; bus.reg_dest = 4'd5;
    tick();
    check("load_kind", bus.trace_data[REC_W-1 -: 4], 4'b0011);
    check("load_inst", inst_count, 2);
    drain(40);

    // overflow: 10 writes into 8 entries, then push with pop when full
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_payload(); bus.reg_write = 1'b1; tick();
    end
    check("ovf_drop", drop_count, 2);
    rand_payload(); bus.reg_write = 1'b1; bus.trace_ready = 1'b1;
    tick();
    check("ovf_drop_hold", drop_count, 2);
    drain(40);

    // halt with buffered records, then frozen counters and drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_payload(); bus.reg_write = 1'b1; tick();
    end
    clear_in(); rand_payload(); bus.hlt = 1'b1;
    tick();
    check("hlt_halted", halted, 1);
    clear_in(); rand_payload(); bus.reg_write = 1'b1;
    tick(); tick();
    check("hlt_frozen_inst", inst_count, 4);
    check("hlt_frozen_cycles", cycle_count, 4);
    drain(20);

    // watchdog without halt
    do_reset();
    for (int i = 0; i < 24; i++) begin
      rand_payload();
      bus.reg_write = 1'($urandom); bus.mem_write = ($urandom_range(0, 3) == 0);
      bus.trace_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    check("wd_timeout", timeout, 1);
    check("wd_halted", halted, 0);
    check("wd_cycles", cycle_count, 20);
    drain(20);

    // halt exactly on the limit cycle
    do_reset();
    repeat (19) tick();
    bus.hlt = 1'b1;
    tick();
    check("lim_halted", halted, 1);
    check("lim_timeout", timeout, 0);
    check("lim_cycles", cycle_count, 20);
    drain(20);

    // async reset in the middle of a drain, then resume RUN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_payload(); bus.mem_write = 1'b1; tick();
    end
    clear_in(); bus.hlt = 1'b1; tick();
    clear_in(); bus.trace_ready = 1'b1; tick();
    do_reset();
    tick();
    check("resume_cycles", cycle_count, 1);
    drain(40);

    // randomised runs
    for (int s = 0; s < 12; s++) begin
      do_reset();
      for (int t = 0; t < 80 && !m_done; t++) begin
        rand_payload();
        bus.hlt = ($urandom_range(0, 24) == 0);
        bus.reg_write = 1'($urandom);
        bus.mem_read = ($urandom_range(0, 3) == 0);
        bus.mem_write = ($urandom_range(0, 3) == 0);
        bus.trace_ready = m_stop ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 2) == 0);
        tick();
      end
      check("random_done", done, 1);
      check("random_scoreboard", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
